// File: rtl/cache_bus_arbiter.sv
// cache_bus_arbiter: round-robin arbiter sharing one cache bus among REQ_NUM masters, holding each grant for a full transaction
// Ports: clk, rst (sync, active-high); req_i/resp_o per-master bus; bus_req_o/bus_resp_i downstream bus;
// grant_o one-hot owner (zero when idle); busy_o high while a transaction is in progress.
package cache_bus_pkg;
  typedef struct packed {
    logic        valid;
    logic        write;
    logic        burst;
    logic        cached;
    logic [31:0] addr;
    logic [31:0] w_data;
    logic [3:0]  data_strobe;
    logic        data_ok;
    logic        data_last;
  } cache_bus_req_t;
  typedef struct packed {
    logic        ready;
    logic        data_ok;
    logic        data_last;
    logic [31:0] r_data;
  } cache_bus_resp_t;
endpackage

module cache_bus_arbiter
  import cache_bus_pkg::*;
#(
  parameter int REQ_NUM = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  cache_bus_req_t  [REQ_NUM-1:0]    req_i,
  output cache_bus_resp_t [REQ_NUM-1:0]    resp_o,
  output cache_bus_req_t                   bus_req_o,
  input  cache_bus_resp_t                  bus_resp_i,
  output logic            [REQ_NUM-1:0]    grant_o,
  output logic                             busy_o
);
  localparam int PW = $clog2(REQ_NUM);
  typedef enum logic [2:0] {IDLE = 3'b001, ADDR = 3'b010, DATA = 3'b100} state_t;
  state_t               r_state, w_state_nxt;
  logic [REQ_NUM-1:0]   r_owner, w_owner_nxt;
  logic [PW-1:0]        r_ptr, w_ptr_nxt, w_win;
  logic                 w_any, w_addr, w_data, w_done;
  cache_bus_req_t       w_sel;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_ptr   <= PW'(REQ_NUM - 1);
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end
  // Scan from farthest to nearest so the lowest offset after r_ptr ends up as winner;
  // offset REQ_NUM is r_ptr itself, letting a lone previous owner win again.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    for (int i = REQ_NUM; i >= 1; i--) begin
      if (req_i[PW'((int'(r_ptr) + i) % REQ_NUM)].valid) begin
        w_any = 1'b1;
        w_win = PW'((int'(r_ptr) + i) % REQ_NUM);
      end
    end
  end
  // While owned, r_ptr holds the owner index, so it doubles as the mux select.
  assign w_sel  = req_i[r_ptr];
  assign w_addr = ~rst & (r_state == ADDR);
  assign w_data = ~rst & (r_state == DATA);
  always_comb begin
    bus_req_o           = (w_addr | w_data) ? w_sel : '0;
    bus_req_o.valid     = w_sel.valid & w_addr;
    bus_req_o.data_ok   = w_sel.data_ok & w_data;
    bus_req_o.data_last = w_sel.data_last & w_data;
  end
  // Writes end on the master's last beat, reads on the bus's last beat.
  assign w_done = bus_resp_i.data_ok & bus_req_o.data_ok &
                  (bus_req_o.write ? bus_req_o.data_last : bus_resp_i.data_last);
  always_comb begin
    resp_o = '0;
    for (int k = 0; k < REQ_NUM; k++) begin
      resp_o[k].ready     = w_addr & (r_ptr == PW'(k)) & bus_resp_i.ready;
      resp_o[k].data_ok   = w_data & (r_ptr == PW'(k)) & bus_resp_i.data_ok;
      resp_o[k].data_last = w_data & (r_ptr == PW'(k)) & bus_resp_i.data_last;
      resp_o[k].r_data    = rst ? '0 : bus_resp_i.r_data;
    end
  end
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    if (r_state == IDLE && w_any) begin
      w_state_nxt = ADDR;
      w_owner_nxt = {{(REQ_NUM-1){1'b0}}, 1'b1} << w_win;
      w_ptr_nxt   = w_win;
    end
    if (r_state == ADDR && bus_resp_i.ready && bus_req_o.valid) w_state_nxt = DATA;
    if (r_state == DATA && w_done) begin
      w_state_nxt = IDLE;
      w_owner_nxt = '0;
    end
  end
  assign grant_o = rst ? '0 : r_owner;
  assign busy_o  = ~rst & (r_state != IDLE);
endmodule
